sram_arbiter_ctrl: RTL and testbench

Shares the single 16-bit off-chip SRAM between two 32-bit requesters: port 0 is the pipeline memory stage, port 1 is a secondary master (debug loader / DMA). Each 32-bit access is sequenced as two 16-bit SRAM phases (low half, then high half) with programmable wait states. Ports are granted round-robin, and a one-cycle `ready` pulse completes each transfer; port 0 uses `ready` as its pipeline freeze release.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/sram_arbiter_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    // word address width: one 32-bit word spans two half-word locations
    localparam int WORD_AW = SRAM_AW - 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the port not granted last wins.
module rr_arbiter2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_id,
    output logic       gnt_valid
);

    logic last_grant;

    // Grant selection from current requests and the previous winner
    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b11:   gnt_id = ~last_grant;
            2'b10:   gnt_id = PORT1;
            default: gnt_id = PORT0;
        endcase
    end

    // Remember the winner; reset to PORT1 so port 0 takes the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= PORT1;
        end else if (grant_en && gnt_valid) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Shares one 16-bit SRAM between two 32-bit requesters. Each word access is
// a low half-word phase then a high half-word phase of WAIT_CYCLES each.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner
// LO    | low half-word on the bus (address even)
// HI    | high half-word on the bus (address odd)
// DONE  | one-cycle ready pulse to the granted port
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p0_rd_en,
    input  logic               p0_wr_en,
    input  logic [31:0]        p0_addr,
    input  logic [31:0]        p0_wdata,
    output logic [31:0]        p0_rdata,
    output logic               p0_ready,
    input  logic               p1_rd_en,
    input  logic               p1_wr_en,
    input  logic [31:0]        p1_addr,
    input  logic [31:0]        p1_wdata,
    output logic [31:0]        p1_rdata,
    output logic               p1_ready,
    output logic               busy,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    // Phase timer is a down-counter loaded with WAIT_CYCLES-1; zero marks
    // the last cycle of a phase (data-hold / sample cycle).
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               gnt_q;
    logic               wr_q;
    logic [WORD_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rbuf;

    logic [1:0]         req;
    logic               grant_en;
    logic               gnt_id;
    logic               gnt_valid;

    logic               sel_wr;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               wr_nxt;
    logic               we_n_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic               tc;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[31:19], p0_addr[1:0],
                                p1_addr[31:19], p1_addr[1:0]};

    assign req = {p1_rd_en | p1_wr_en, p0_rd_en | p0_wr_en};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant_en  (grant_en),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Mux the winning port's request fields; write wins when both enables are high
    always_comb begin
        if (gnt_id == PORT1) begin
            sel_wr    = p1_wr_en;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end else begin
            sel_wr    = p0_wr_en;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end
    end

    assign tc = (cnt == 4'd0);

    // Next state, phase timer and next values of the registered SRAM controls
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_en  = 1'b0;
        wr_nxt    = wr_q;
        addr_nxt  = SRAM_ADDR;
        we_n_nxt  = 1'b1;
        case (state)
            IDLE: begin
                grant_en = 1'b1;
                if (gnt_valid) begin
                    state_nxt = LO;
                    cnt_nxt   = WAIT_LOAD;
                    wr_nxt    = sel_wr;
                    addr_nxt  = {sel_addr[18:2], 1'b0};
                end
            end
            LO: begin
                if (tc) begin
                    state_nxt = HI;
                    cnt_nxt   = WAIT_LOAD;
                    addr_nxt  = {addr_q, 1'b1};
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HI: begin
                if (tc) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if ((state_nxt == LO || state_nxt == HI) && wr_nxt && (cnt_nxt != 4'd0)) begin
            we_n_nxt = 1'b0;
        end
    end

    // State, timer and SRAM control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            SRAM_ADDR <= addr_nxt;
            SRAM_WE_N <= we_n_nxt;
        end
    end

    // Latch the granted request so the requester's later changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= PORT0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && gnt_valid) begin
            gnt_q   <= gnt_id;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr[18:2];
            wdata_q <= sel_wdata;
        end
    end

    // Capture read half-words on the last phase cycle; load rdata entering DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbuf     <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (!wr_q && tc) begin
            if (state == LO) begin
                rbuf[15:0] <= SRAM_DQ;
            end else if (state == HI) begin
                rbuf[31:16] <= SRAM_DQ;
                if (gnt_q == PORT1) begin
                    p1_rdata <= {SRAM_DQ, rbuf[15:0]};
                end else begin
                    p0_rdata <= {SRAM_DQ, rbuf[15:0]};
                end
            end
        end
    end

    assign p0_ready = (state == DONE) && (gnt_q == PORT0);
    assign p1_ready = (state == DONE) && (gnt_q == PORT1);
    assign busy     = (state != IDLE);

    assign SRAM_DQ = (wr_q && state == LO) ? wdata_q[15:0]  :
                     (wr_q && state == HI) ? wdata_q[31:16] : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl: W=2 instance on both ports and a
// W=4 instance on port 0, each with a simple half-word SRAM model.
module tb_sram_arbiter_ctrl;

    logic        clk;
    logic        rst;

    logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    wire  [31:0] p0_rdata, p1_rdata;
    wire         p0_ready, p1_ready, busy2;
    wire  [15:0] dq2;
    wire  [17:0] addr2;
    wire         we2;

    logic        q_rd, q_wr;
    logic [31:0] q_addr, q_wdata;
    wire  [31:0] q_rdata, q1_rdata;
    wire         q_ready, q1_ready, busy4;
    wire  [15:0] dq4;
    wire  [17:0] addr4;
    wire         we4;

    logic        oe2, oe4;
    logic [15:0] mem2 [0:255];
    logic [15:0] mem4 [0:255];
    logic        pre2, pre4;
    logic [7:0]  pre_a;
    logic [15:0] pre_d;

    int checks = 0;
    int failures = 0;

    sram_arbiter_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .busy(busy2), .SRAM_DQ(dq2), .SRAM_ADDR(addr2), .SRAM_WE_N(we2)
    );

    sram_arbiter_ctrl #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .p0_rd_en(q_rd), .p0_wr_en(q_wr), .p0_addr(q_addr), .p0_wdata(q_wdata),
        .p0_rdata(q_rdata), .p0_ready(q_ready),
        .p1_rd_en(1'b0), .p1_wr_en(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_rdata(q1_rdata), .p1_ready(q1_ready),
        .busy(busy4), .SRAM_DQ(dq4), .SRAM_ADDR(addr4), .SRAM_WE_N(we4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: drive on reads, capture while WE_N is low, or take a preset
    assign dq2 = oe2 ? mem2[addr2[7:0]] : 16'hzzzz;
    assign dq4 = oe4 ? mem4[addr4[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (pre2) mem2[pre_a] = pre_d;
        else if (!we2) mem2[addr2[7:0]] = dq2;
        if (pre4) mem4[pre_a] = pre_d;
        else if (!we4) mem4[addr4[7:0]] = dq4;
    end

    task automatic preset(input bit sel4, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_a = a; pre_d = d; pre2 = !sel4; pre4 = sel4;
        @(negedge clk);
        pre2 = 1'b0; pre4 = 1'b0;
    endtask

    task automatic drop_all();
        p0_rd_en = 0; p0_wr_en = 0; p1_rd_en = 0; p1_wr_en = 0; q_rd = 0; q_wr = 0;
    endtask

    // Issue one access starting in an IDLE cycle (cycle 0) and watch for ready
    task automatic do_access(input bit sel4, input bit port, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] wd, input int max_cyc,
                             output int rdy_cyc, output logic [31:0] we_mask,
                             output logic [17:0] addr_c1);
        logic rdy, wen;
        logic [17:0] sa;
        @(posedge clk); #1;
        rdy_cyc = -1; we_mask = '0; addr_c1 = '0;
        if (sel4) begin
            q_rd = rd; q_wr = wr; q_addr = a; q_wdata = wd; oe4 = rd && !wr;
        end else if (port) begin
            p1_rd_en = rd; p1_wr_en = wr; p1_addr = a; p1_wdata = wd; oe2 = rd && !wr;
        end else begin
            p0_rd_en = rd; p0_wr_en = wr; p0_addr = a; p0_wdata = wd; oe2 = rd && !wr;
        end
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            rdy = sel4 ? q_ready : (port ? p1_ready : p0_ready);
            wen = sel4 ? we4 : we2;
            sa  = sel4 ? addr4 : addr2;
            if (!wen && n < 32) we_mask[n] = 1'b1;
            if (n == 1) addr_c1 = sa;
            if (rdy) begin
                rdy_cyc = n;
                break;
            end
        end
        drop_all();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (addr2 !== 18'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr2); end
        checks++; if (we2 !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", we2); end
        checks++; if ({p0_ready, p1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {p0_ready, p1_ready}); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        @(negedge clk);
        rst = 1'b1;
        preset(1'b0, 8'h00, 16'hA5C3);
        oe2 = 1'b1;
        #1;
        checks++; if (dq2 !== 16'hA5C3) begin failures++; $display("FAIL idle_dq_released got=%h exp=a5c3", dq2); end
        oe2 = 1'b0;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy2); end
    endtask

    task automatic test_single_read();
        int rc; logic [31:0] wm; logic [17:0] a1;
        preset(1'b0, 8'h08, 16'hBEEF);
        preset(1'b0, 8'h09, 16'hDEAD);
        do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 20, rc, wm, a1);
        checks++; if (rc !== 5) begin failures++; $display("FAIL read_ready_cycle got=%0d exp=5", rc); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=deadbeef", p0_rdata); end
        checks++; if (a1 !== 18'h8) begin failures++; $display("FAIL read_lo_addr got=%h exp=8", a1); end
        checks++; if (wm !== 32'h0) begin failures++; $display("FAIL read_we_n got=%h exp=0", wm); end
    endtask

    task automatic test_write_read();
        int rc; logic [31:0] wm; logic [17:0] a1;
        do_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 20, rc, wm, a1);
        checks++; if (rc !== 5) begin failures++; $display("FAIL write_ready_cycle got=%0d exp=5", rc); end
        checks++; if (wm !== 32'hA) begin failures++; $display("FAIL write_we_cycles got=%h exp=a", wm); end
        checks++; if (mem2[8'h10] !== 16'h5678) begin failures++; $display("FAIL write_mem_lo got=%h exp=5678", mem2[8'h10]); end
        checks++; if (mem2[8'h11] !== 16'h1234) begin failures++; $display("FAIL write_mem_hi got=%h exp=1234", mem2[8'h11]); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=deadbeef", p0_rdata); end
        do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 20, rc, wm, a1);
        checks++; if (rc !== 5) begin failures++; $display("FAIL readback_ready_cycle got=%0d exp=5", rc); end
        checks++; if (p0_rdata !== 32'h12345678) begin failures++; $display("FAIL readback_rdata got=%h exp=12345678", p0_rdata); end
    endtask

    task automatic test_back_to_back_tie();
        int c0 [2];
        int c1;
        int k0;
        preset(1'b0, 8'h20, 16'h1111);
        preset(1'b0, 8'h21, 16'h2222);
        preset(1'b0, 8'h40, 16'h3333);
        preset(1'b0, 8'h41, 16'h4444);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        c0[0] = -1; c0[1] = -1; c1 = -1; k0 = 0;
        @(posedge clk); #1;
        oe2 = 1'b1;
        p0_rd_en = 1'b1; p0_addr = 32'h40;
        p1_rd_en = 1'b1; p1_addr = 32'h80;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (p0_ready && k0 < 2) begin
                c0[k0] = n;
                k0++;
                if (k0 == 2) p0_rd_en = 1'b0;
            end
            if (p1_ready) begin
                c1 = n;
                p1_rd_en = 1'b0;
            end
            if (k0 == 2 && c1 >= 0) break;
        end
        drop_all();
        checks++; if (c0[0] !== 5) begin failures++; $display("FAIL tie_p0_first got=%0d exp=5", c0[0]); end
        checks++; if (c1 !== 11) begin failures++; $display("FAIL tie_p1_second got=%0d exp=11", c1); end
        checks++; if (c0[1] !== 17) begin failures++; $display("FAIL tie_p0_again got=%0d exp=17", c0[1]); end
        checks++; if (p0_rdata !== 32'h22221111) begin failures++; $display("FAIL tie_p0_rdata got=%h exp=22221111", p0_rdata); end
        checks++; if (p1_rdata !== 32'h44443333) begin failures++; $display("FAIL tie_p1_rdata got=%h exp=44443333", p1_rdata); end
    endtask

    task automatic test_rd_wr_both();
        int rc; logic [31:0] wm; logic [17:0] a1;
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h60, 32'hCAFEF00D, 20, rc, wm, a1);
        checks++; if (rc !== 5) begin failures++; $display("FAIL rdwr_ready_cycle got=%0d exp=5", rc); end
        checks++; if (mem2[8'h30] !== 16'hF00D || mem2[8'h31] !== 16'hCAFE) begin failures++; $display("FAIL rdwr_mem got=%h%h exp=cafef00d", mem2[8'h31], mem2[8'h30]); end
        checks++; if (p1_rdata !== 32'h44443333) begin failures++; $display("FAIL rdwr_p1_rdata got=%h exp=44443333", p1_rdata); end
        checks++; if (wm !== 32'hA) begin failures++; $display("FAIL rdwr_we_cycles got=%h exp=a", wm); end
    endtask

    task automatic test_reset_mid();
        int rc; logic [31:0] wm; logic [17:0] a1;
        bit seen;
        @(posedge clk); #1;
        oe2 = 1'b0;
        p0_wr_en = 1'b1; p0_addr = 32'h100; p0_wdata = 32'hA5A55A5A;
        repeat (4) @(negedge clk);
        checks++; if (busy2 !== 1'b1 || addr2 !== 18'h81) begin failures++; $display("FAIL mid_in_hi got busy=%b addr=%h exp busy=1 addr=81", busy2, addr2); end
        rst = 1'b0;
        drop_all();
        #1;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy2); end
        checks++; if (addr2 !== 18'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", addr2); end
        checks++; if (we2 !== 1'b1) begin failures++; $display("FAIL mid_we_n got=%b exp=1", we2); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (p0_ready || p1_ready) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_ready got=%b exp=0", seen); end
        do_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hA5A55A5A, 20, rc, wm, a1);
        checks++; if (rc !== 5) begin failures++; $display("FAIL reissue_ready_cycle got=%0d exp=5", rc); end
        checks++; if (mem2[8'h80] !== 16'h5A5A || mem2[8'h81] !== 16'hA5A5) begin failures++; $display("FAIL reissue_mem got=%h%h exp=a5a55a5a", mem2[8'h81], mem2[8'h80]); end
    endtask

    task automatic test_wait4();
        int rc; logic [31:0] wm; logic [17:0] a1;
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 30, rc, wm, a1);
        checks++; if (rc !== 9) begin failures++; $display("FAIL w4_write_ready got=%0d exp=9", rc); end
        checks++; if (wm !== 32'hEE) begin failures++; $display("FAIL w4_we_cycles got=%h exp=ee", wm); end
        checks++; if (mem4[8'h10] !== 16'hF00D || mem4[8'h11] !== 16'h0BAD) begin failures++; $display("FAIL w4_mem got=%h%h exp=0badf00d", mem4[8'h11], mem4[8'h10]); end
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 30, rc, wm, a1);
        checks++; if (rc !== 9) begin failures++; $display("FAIL w4_read_ready got=%0d exp=9", rc); end
        checks++; if (q_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL w4_rdata got=%h exp=0badf00d", q_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        oe2 = 1'b0; oe4 = 1'b0;
        pre2 = 1'b0; pre4 = 1'b0; pre_a = '0; pre_d = '0;
        p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
        q_addr = '0; q_wdata = '0;
        drop_all();
        #3;
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back_tie();
        test_rd_wr_both();
        test_reset_mid();
        test_wait4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
